// File: rtl/vote_tally_bcd.sv
// vote_tally_bcd
//   Synchronous ballot tally. Keeps one DIGITS-digit packed-BCD counter per
//   candidate (the last index is the null/blank tally) plus a DIGITS+1 digit
//   BCD grand total. Counters saturate at all-nines instead of wrapping. When
//   the election is finished a one-index-per-cycle scan finds the leader among
//   the real candidates and flags a shared maximum.
//
// Ports
//   clock       system clock, all state changes on the rising edge
//   reset       asynchronous active-low reset, clears all state
//   clear       synchronous clear, same effect as reset, beats every other input
//   vote_valid  a vote is offered this cycle
//   vote_cand   candidate index of the offered vote (out of range -> null tally)
//   vote_ready  vote can be accepted this cycle (COUNT state and no clear)
//   finish      end-of-election request, honoured in COUNT only
//   rd_sel      readout select; NUM_CAND selects the total, larger values read 0
//   rd_count    registered readout, packed BCD, one cycle after rd_sel
//   sat         sticky per-tally saturation flags
//   state_o     FSM state: 0=COUNT, 1=SCAN, 2=DONE
//   done        high in DONE
//   leader      winning tally index, valid while done=1
//   tie         maximum shared by more than one candidate, valid while done=1
module vote_tally_bcd #(
   parameter int NUM_CAND = 5,
   parameter int DIGITS   = 6
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic                            clear,
   input  logic                            vote_valid,
   input  logic [$clog2(NUM_CAND)-1:0]     vote_cand,
   output logic                            vote_ready,
   input  logic                            finish,
   input  logic [$clog2(NUM_CAND+1)-1:0]   rd_sel,
   output logic [4*(DIGITS+1)-1:0]         rd_count,
   output logic [NUM_CAND-1:0]             sat,
   output logic [1:0]                      state_o,
   output logic                            done,
   output logic [$clog2(NUM_CAND)-1:0]     leader,
   output logic                            tie
);

   localparam int CW   = $clog2(NUM_CAND);
   localparam int TW   = 4 * DIGITS;
   localparam int SUMW = 4 * (DIGITS + 1);

   localparam logic [1:0] COUNT = 2'd0;
   localparam logic [1:0] SCAN  = 2'd1;
   localparam logic [1:0] DONE  = 2'd2;

   localparam logic [CW-1:0] NULL_IDX  = CW'(NUM_CAND - 1);
   localparam logic [CW-1:0] LAST_SCAN = CW'(NUM_CAND - 2);

   // True when every digit of a tally is 9.
   function automatic logic tally_full(input logic [TW-1:0] v);
      logic f;
      f = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (v[4*i +: 4] != 4'd9) f = 1'b0;
      end
      return f;
   endfunction

   // Digit-wise BCD increment; a carry out of the top digit means the value
   // was all nines, in which case the input is returned unchanged.
   function automatic logic [TW-1:0] tally_inc(input logic [TW-1:0] v);
      logic [TW-1:0] r;
      logic          carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      if (carry) r = v;
      return r;
   endfunction

   // Same saturating increment for the wider grand total.
   function automatic logic [SUMW-1:0] total_inc(input logic [SUMW-1:0] v);
      logic [SUMW-1:0] r;
      logic            carry;
      r     = v;
      carry = 1'b1;
      for (int i = 0; i < DIGITS + 1; i++) begin
         if (carry) begin
            if (v[4*i +: 4] == 4'd9) begin
               r[4*i +: 4] = 4'd0;
            end else begin
               r[4*i +: 4] = v[4*i +: 4] + 4'd1;
               carry       = 1'b0;
            end
         end
      end
      if (carry) r = v;
      return r;
   endfunction

   logic [1:0]      state;
   logic [TW-1:0]   tally [NUM_CAND];
   logic [SUMW-1:0] total;
   logic [TW-1:0]   max_val;
   logic [CW-1:0]   scan_idx;
   logic [CW-1:0]   vidx;
   logic            accept;

   // Out-of-range candidate indices are counted as null votes.
   always_comb begin
      vidx = vote_cand;
      if (int'(vote_cand) >= NUM_CAND) vidx = NULL_IDX;
   end

   assign vote_ready = (state == COUNT) && !clear;
   assign accept     = vote_valid && vote_ready;
   assign state_o    = state;
   assign done       = (state == DONE);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state    <= COUNT;
         tally    <= '{default: '0};
         total    <= '0;
         sat      <= '0;
         max_val  <= '0;
         scan_idx <= '0;
         leader   <= '0;
         tie      <= 1'b0;
      end else if (clear) begin
         state    <= COUNT;
         tally    <= '{default: '0};
         total    <= '0;
         sat      <= '0;
         max_val  <= '0;
         scan_idx <= '0;
         leader   <= '0;
         tie      <= 1'b0;
      end else begin
         // A vote accepted alongside finish is counted before the scan reads
         // any tally, since the scan starts on the following cycle.
         if (accept) begin
            if (tally_full(tally[vidx])) begin
               sat[vidx] <= 1'b1;
            end else begin
               tally[vidx] <= tally_inc(tally[vidx]);
            end
            total <= total_inc(total);
         end

         case (state)
            COUNT: begin
               if (finish) begin
                  state    <= SCAN;
                  scan_idx <= '0;
               end
            end
            SCAN: begin
               // Packed BCD compares correctly as unsigned binary because no
               // digit ever exceeds 9. The null tally is never visited.
               if (scan_idx == '0) begin
                  max_val <= tally[0];
                  leader  <= '0;
                  tie     <= 1'b0;
               end else if (tally[scan_idx] > max_val) begin
                  max_val <= tally[scan_idx];
                  leader  <= scan_idx;
                  tie     <= 1'b0;
               end else if (tally[scan_idx] == max_val) begin
                  tie <= 1'b1;
               end
               if (scan_idx == LAST_SCAN) begin
                  state <= DONE;
               end else begin
                  scan_idx <= scan_idx + 1'b1;
               end
            end
            DONE: begin
               state <= DONE;
            end
            default: begin
               state <= COUNT;
            end
         endcase
      end
   end

   // Readout samples the tallies as they stood before this edge.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rd_count <= '0;
      end else if (clear) begin
         rd_count <= '0;
      end else if (int'(rd_sel) < NUM_CAND) begin
         rd_count <= {4'h0, tally[rd_sel[CW-1:0]]};
      end else if (int'(rd_sel) == NUM_CAND) begin
         rd_count <= total;
      end else begin
         rd_count <= '0;
      end
   end

endmodule

// File: tb/tb_vote_tally_bcd.sv
module tb_vote_tally_bcd;

   localparam int NC = 5;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       clear = 1'b0;
   logic       vote_valid = 1'b0;
   logic       finish = 1'b0;
   logic [2:0] vote_cand = '0;
   logic [2:0] rd_sel = '0;

   logic [27:0] rd6;
   logic [11:0] rd2;
   logic [7:0]  rd1;
   logic [4:0]  sat6, sat2, sat1;
   logic [1:0]  st6, st2, st1;
   logic        done6, done2, done1;
   logic        rdy6, rdy2, rdy1;
   logic [2:0]  ld6, ld2, ld1;
   logic        tie6, tie2, tie1;

   int errors = 0;
   int checks = 0;
   bit en = 1'b0;
   int rot = 0;

   vote_tally_bcd #(.NUM_CAND(NC), .DIGITS(6)) u6 (
      .clock(clock), .reset(reset), .clear(clear), .vote_valid(vote_valid),
      .vote_cand(vote_cand), .vote_ready(rdy6), .finish(finish), .rd_sel(rd_sel),
      .rd_count(rd6), .sat(sat6), .state_o(st6), .done(done6), .leader(ld6), .tie(tie6));
   vote_tally_bcd #(.NUM_CAND(NC), .DIGITS(2)) u2 (
      .clock(clock), .reset(reset), .clear(clear), .vote_valid(vote_valid),
      .vote_cand(vote_cand), .vote_ready(rdy2), .finish(finish), .rd_sel(rd_sel),
      .rd_count(rd2), .sat(sat2), .state_o(st2), .done(done2), .leader(ld2), .tie(tie2));
   vote_tally_bcd #(.NUM_CAND(NC), .DIGITS(1)) u1 (
      .clock(clock), .reset(reset), .clear(clear), .vote_valid(vote_valid),
      .vote_cand(vote_cand), .vote_ready(rdy1), .finish(finish), .rd_sel(rd_sel),
      .rd_count(rd1), .sat(sat1), .state_o(st1), .done(done1), .leader(ld1), .tie(tie1));

   always #5 clock = ~clock;

   // Behavioural model: plain integer vote counts capped at 10^D-1.
   int         dig [3] = '{6, 2, 1};
   int         mt [3][NC];
   int         mtot [3];
   logic [4:0] msat [3];
   int         mmode [3];   // 0 counting, 1 scanning, 2 done
   int         mcnt [3];
   int         mleader [3];
   bit         mtie [3];
   int         mrd [3];

   function automatic int pow10(input int n);
      int r = 1;
      for (int i = 0; i < n; i++) r = r * 10;
      return r;
   endfunction

   function automatic logic [31:0] to_bcd(input int v);
      logic [31:0] r = '0;
      int x = v;
      for (int i = 0; i < 8; i++) begin
         r[4*i +: 4] = 4'(x % 10);
         x = x / 10;
      end
      return r;
   endfunction

   task automatic model_zero(input int k);
      for (int i = 0; i < NC; i++) mt[k][i] = 0;
      mtot[k] = 0; msat[k] = '0; mmode[k] = 0; mcnt[k] = 0;
      mleader[k] = 0; mtie[k] = 1'b0; mrd[k] = 0;
   endtask

   task automatic model_step();
      int c, mx, nmax, lead;
      for (int k = 0; k < 3; k++) begin
         if (int'(rd_sel) < NC) mrd[k] = mt[k][rd_sel];
         else if (int'(rd_sel) == NC) mrd[k] = mtot[k];
         else mrd[k] = 0;
         if (clear) begin
            model_zero(k);
         end else begin
            if (mmode[k] == 0 && vote_valid) begin
               c = int'(vote_cand);
               if (c >= NC) c = NC - 1;
               if (mt[k][c] == pow10(dig[k]) - 1) msat[k][c] = 1'b1;
               else mt[k][c] = mt[k][c] + 1;
               if (mtot[k] < pow10(dig[k] + 1) - 1) mtot[k] = mtot[k] + 1;
            end
            if (mmode[k] == 0 && finish) begin
               mmode[k] = 1;
               mcnt[k]  = NC - 1;
            end else if (mmode[k] == 1) begin
               mcnt[k] = mcnt[k] - 1;
               if (mcnt[k] == 0) begin
                  mmode[k] = 2;
                  mx = 0;
                  for (int i = 0; i < NC - 1; i++) if (mt[k][i] > mx) mx = mt[k][i];
                  nmax = 0; lead = -1;
                  for (int i = 0; i < NC - 1; i++) begin
                     if (mt[k][i] == mx) begin
                        nmax++;
                        if (lead < 0) lead = i;
                     end
                  end
                  mleader[k] = lead;
                  mtie[k]    = (nmax > 1);
               end
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < 3; k++) model_zero(k);
      forever begin
         @(posedge clock or negedge reset);
         if (!reset) begin
            for (int k = 0; k < 3; k++) model_zero(k);
         end else begin
            model_step();
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      logic [31:0] a_rd [3];
      logic [31:0] a_sat [3];
      logic [31:0] a_st [3];
      logic [31:0] a_dn [3];
      logic [31:0] a_rdy [3];
      logic [31:0] a_ld [3];
      logic [31:0] a_tie [3];
      a_rd[0] = 32'(rd6);   a_rd[1] = 32'(rd2);   a_rd[2] = 32'(rd1);
      a_sat[0] = 32'(sat6); a_sat[1] = 32'(sat2); a_sat[2] = 32'(sat1);
      a_st[0] = 32'(st6);   a_st[1] = 32'(st2);   a_st[2] = 32'(st1);
      a_dn[0] = 32'(done6); a_dn[1] = 32'(done2); a_dn[2] = 32'(done1);
      a_rdy[0] = 32'(rdy6); a_rdy[1] = 32'(rdy2); a_rdy[2] = 32'(rdy1);
      a_ld[0] = 32'(ld6);   a_ld[1] = 32'(ld2);   a_ld[2] = 32'(ld1);
      a_tie[0] = 32'(tie6); a_tie[1] = 32'(tie2); a_tie[2] = 32'(tie1);
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("rd_count d%0d", dig[k]), a_rd[k], to_bcd(mrd[k]));
         chk($sformatf("sat d%0d", dig[k]), a_sat[k], 32'(msat[k]));
         chk($sformatf("state d%0d", dig[k]), a_st[k], 32'(mmode[k]));
         chk($sformatf("done d%0d", dig[k]), a_dn[k], (mmode[k] == 2) ? 32'd1 : 32'd0);
         chk($sformatf("vote_ready d%0d", dig[k]), a_rdy[k],
             (mmode[k] == 0 && !clear) ? 32'd1 : 32'd0);
         if (mmode[k] != 1) begin
            chk($sformatf("leader d%0d", dig[k]), a_ld[k], 32'(mleader[k]));
            chk($sformatf("tie d%0d", dig[k]), a_tie[k], 32'(mtie[k]));
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clock);
         if (en) compare_all();
      end
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic vote(input int c, input int n);
      for (int i = 0; i < n; i++) begin
         vote_valid = 1'b1;
         vote_cand  = 3'(c);
         rd_sel     = 3'(rot);
         rot        = (rot + 1) % 8;
         tick();
      end
      vote_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1; vote_valid = 1'b1; vote_cand = 3'd1;
      tick();
      clear = 1'b0; vote_valid = 1'b0;
   endtask

   task automatic sweep();
      for (int s = 0; s < 8; s++) begin
         rd_sel = 3'(s);
         tick();
      end
   endtask

   task automatic read_at(input int s);
      rd_sel = 3'(s);
      tick();
      @(negedge clock);
   endtask

   initial begin
      #2 reset = 1'b0;
      #1 en = 1'b1;
      repeat (2) @(posedge clock);
      #3 reset = 1'b1;
      @(negedge clock);
      chk("reset rd_count", 32'(rd6), 32'h0);
      chk("reset state", 32'(st6), 32'h0);
      chk("reset ready", 32'(rdy6), 32'h1);
      tick();

      // Basic counting and readout
      vote(1, 3); vote(2, 2);
      read_at(1); chk("tally idx1", 32'(rd6), 32'h0000003);
      read_at(5); chk("total", 32'(rd6), 32'h0000005);

      // BCD carry at 9 -> 10 on the two-digit instance
      do_clear();
      vote(0, 9);
      read_at(0); chk("d2 nine", 32'(rd2), 32'h009);
      vote(0, 1);
      read_at(0); chk("d2 carry", 32'(rd2), 32'h010);
      vote(0, 2);
      read_at(0); chk("d2 tally12", 32'(rd2), 32'h012);
      read_at(5); chk("d2 total12", 32'(rd2), 32'h012);

      // Saturation on the one-digit instance
      do_clear();
      vote(3, 10);
      read_at(3); chk("d1 sat tally", 32'(rd1), 32'h09);
      chk("d1 sat flag", 32'(sat1[3]), 32'h1);
      chk("d1 ready after sat", 32'(rdy1), 32'h1);
      read_at(5); chk("d1 total", 32'(rd1), 32'h10);

      // Out-of-range candidate folds into the null tally
      do_clear();
      vote(7, 1);
      read_at(4); chk("null fold", 32'(rd6), 32'h1);
      read_at(0); chk("idx0 untouched", 32'(rd6), 32'h0);
      sweep();

      // Tie between 1 and 2, null excluded, finish with a vote
      do_clear();
      vote(0, 2); vote(1, 5); vote(2, 5); vote(3, 1); vote(4, 9);
      vote_valid = 1'b1; vote_cand = 3'd0; finish = 1'b1;
      tick();
      finish = 1'b0; vote_cand = 3'd3;
      @(negedge clock);
      chk("scan state", 32'(st6), 32'h1);
      chk("scan ready", 32'(rdy6), 32'h0);
      repeat (4) tick();
      @(negedge clock);
      chk("done", 32'(done6), 32'h1);
      chk("leader tie case", 32'(ld6), 32'h1);
      chk("tie flag", 32'(tie6), 32'h1);
      chk("done ready", 32'(rdy6), 32'h0);
      finish = 1'b1;
      repeat (2) tick();
      finish = 1'b0; vote_valid = 1'b0;
      read_at(0); chk("idx0 with finish vote", 32'(rd6), 32'h3);
      sweep();

      // Unique leader
      do_clear();
      vote(2, 3); vote(0, 1); vote(4, 5);
      finish = 1'b1; tick(); finish = 1'b0;
      repeat (4) tick();
      @(negedge clock);
      chk("unique leader", 32'(ld6), 32'h2);
      chk("unique no tie", 32'(tie6), 32'h0);

      // Clear in the second scan cycle together with a vote
      do_clear();
      vote(1, 10); vote(2, 2);
      finish = 1'b1; tick(); finish = 1'b0;
      tick();
      clear = 1'b1; vote_valid = 1'b1; vote_cand = 3'd1;
      tick();
      clear = 1'b0; vote_valid = 1'b0;
      @(negedge clock);
      chk("clear scan state", 32'(st6), 32'h0);
      chk("clear sat", 32'(sat1), 32'h0);
      sweep();

      // Asynchronous reset pulse mid-scan
      vote(1, 10); vote(3, 4);
      finish = 1'b1; tick(); finish = 1'b0;
      tick();
      #2 reset = 1'b0;
      @(negedge clock);
      chk("areset state", 32'(st6), 32'h0);
      chk("areset sat", 32'(sat1), 32'h0);
      chk("areset rd", 32'(rd6), 32'h0);
      #2 reset = 1'b1;
      sweep();
      vote(2, 1);
      sweep();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vote_tally_bcd.md
Name: vote_tally_bcd

Overview:
- Synchronous, parametrised replacement for the per-candidate ripple-clocked BCD counter chains behind the ballot FSM.
- Holds one DIGITS-digit packed-BCD tally per candidate plus a BCD grand total, all clocked on the system clock.
- Accepts votes via a valid/ready handshake, saturates instead of wrapping, and serves a registered readout port.
- On finish, runs a sequential leader scan that reports the winner index and a tie flag.

Parameters:
- NUM_CAND, 5, number of tallies including the null tally; minimum 2. Index NUM_CAND-1 is the null/blank tally.
- DIGITS, 6, BCD digits per candidate tally; minimum 1. The total has DIGITS+1 digits.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low; clears all state.
- clear  in  1  synchronous clear of tallies, flags and FSM; takes priority over every other input.
- vote_valid  in  1  vote offered this cycle.
- vote_cand  in  $clog2(NUM_CAND)  candidate index of the offered vote.
- vote_ready  out  1  block can accept a vote; combinational: (state==COUNT) && !clear.
- finish  in  1  end-of-election request; acts in COUNT only.
- rd_sel  in  $clog2(NUM_CAND+1)  readout select; the value NUM_CAND selects the total.
- rd_count  out  4*(DIGITS+1)  registered readout, packed BCD, least significant digit at [3:0].
- sat  out  NUM_CAND  sticky per-tally saturation flags.
- state_o  out  2  FSM state: 0=COUNT, 1=SCAN, 2=DONE.
- done  out  1  high in DONE.
- leader  out  $clog2(NUM_CAND)  index of the winning tally, valid when done=1.
- tie  out  1  the maximum tally is shared by more than one candidate, valid when done=1.

Behaviour:
- Reset (reset=0, async) and clear (sync) do the same thing:
  - every tally, the total, sat, rd_count, leader and tie go to 0;
  - done=0 and state=COUNT.
- Vote acceptance: a vote is accepted when vote_valid && vote_ready at a rising edge. The tally and total update at that same edge (0-cycle latency).
- Out-of-range vote_cand (>= NUM_CAND) folds into the null tally NUM_CAND-1.
- BCD increment is done digit-wise: digit 9 goes to 0 with a carry; digits never hold A-F.
- Saturation:
  - A tally that is all 9s stays at all 9s on an accepted vote and sets its sat bit.
  - The total saturates the same way at DIGITS+1 nines; the total has no flag.
  - sat bits clear only on reset or clear.
- Readout: rd_count is registered with 1-cycle latency and is updated in every state.
  - rd_sel < NUM_CAND returns that tally, zero-extended by one digit.
  - rd_sel == NUM_CAND returns the total.
  - Any other rd_sel value returns 0.
- FSM:
  - COUNT: finish=1 moves to SCAN at the next edge. A vote accepted in the same cycle is counted before the scan starts.
  - SCAN: visits indices 0 to NUM_CAND-2, one per cycle (the null tally is excluded), i.e. NUM_CAND-1 cycles, then moves to DONE.
    - Index 0 seeds max, leader=0 and tie=0.
    - A later tally greater than max replaces max, sets leader to its index and clears tie.
    - A later tally equal to max sets tie.
    - Comparison is an unsigned compare of the packed BCD vectors, which is valid because digits stay in 0-9.
  - DONE: done=1; leader and tie are held; votes are refused; finish is ignored. The block leaves DONE only on clear or reset.
  - vote_ready=0 in SCAN and DONE; vote_valid is ignored there.
- Simultaneous events:
  - clear with vote_valid: no vote is counted; clear wins.
  - clear during SCAN: aborts the scan and returns to COUNT with zeroed state.
  - Reset mid-scan: same as clear, applied asynchronously.

Test Plan:
- Reset, then 3 votes for idx 1 and 2 for idx 2 → rd_sel=1 gives rd_count=0x0000003 one cycle later; rd_sel=5 gives 0x0000005.
- DIGITS=2, 12 votes for idx 0 → rd_count=0x012; total=0x012; BCD carry checked at 9→10.
- DIGITS=1, 10 votes for idx 3 → tally holds 0x9; sat[3]=1; total=0x10; vote_ready stays 1.
- vote_cand=7 with NUM_CAND=5 → the null tally (idx 4) increments; the other tallies are unchanged.
- Tallies {2,5,5,1,9} then finish pulsed together with a vote for idx 0 → idx 0 counted as 3; after 4 SCAN cycles done=1, leader=1, tie=1; null excluded; vote_ready=0.
- clear asserted in the 2nd SCAN cycle together with vote_valid → state=COUNT, all tallies 0, sat=0, no vote counted; a reset pulse mid-scan gives the same result asynchronously.
